// File: rtl/sram_rr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sram_rr_access_ctrl
// Two-requester round-robin access controller for a single-port SRAM, with
// an optional post-reset init sweep and in-order, one-cycle-latency responses.
// Rev    : 1.0
// ============================================================================
module sram_rr_access_ctrl #(
    parameter int              AW         = 6,
    parameter int              DW         = 32,
    parameter int              DEPTH      = 64,
    parameter int              INIT_EN    = 1,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_a,
    output logic          req_ready_a,
    input  logic          req_we_a,
    input  logic [AW-1:0] req_addr_a,
    input  logic [DW-1:0] req_wdata_a,
    output logic          rsp_valid_a,
    output logic [DW-1:0] rsp_rdata_a,
    input  logic          req_valid_b,
    output logic          req_ready_b,
    input  logic          req_we_b,
    input  logic [AW-1:0] req_addr_b,
    input  logic [DW-1:0] req_wdata_b,
    output logic          rsp_valid_b,
    output logic [DW-1:0] rsp_rdata_b,
    output logic          init_done,
    output logic          sram_ce_n,
    output logic          sram_we_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wd,
    input  logic [DW-1:0] sram_rd
);

    localparam logic [0:0]    c_st_init   = 1'b0;
    localparam logic [0:0]    c_st_run    = 1'b1;
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_last_b;
    logic          r_ce_n;
    logic          r_we_n;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wd;
    logic          r_p_valid;
    logic          r_p_id;
    logic          r_p_rd;
    logic          r_rsp_valid_a;
    logic          r_rsp_valid_b;
    logic [DW-1:0] r_rsp_rdata_a;
    logic [DW-1:0] r_rsp_rdata_b;
    logic          r_init_done;

    logic          w_gnt_a;
    logic          w_gnt_b;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        w_gnt_a = (r_state == c_st_run) && req_valid_a && (!req_valid_b || r_last_b);
        w_gnt_b = (r_state == c_st_run) && req_valid_b && (!req_valid_a || !r_last_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_init;
            r_cnt         <= '0;
            r_last_b      <= 1'b0;
            r_ce_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_addr        <= '0;
            r_wd          <= '0;
            r_p_valid     <= 1'b0;
            r_p_id        <= 1'b0;
            r_p_rd        <= 1'b0;
            r_rsp_valid_a <= 1'b0;
            r_rsp_valid_b <= 1'b0;
            r_rsp_rdata_a <= '0;
            r_rsp_rdata_b <= '0;
            r_init_done   <= 1'b0;
        end else begin
            r_ce_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_p_valid     <= 1'b0;
            r_rsp_valid_a <= r_p_valid && !r_p_id;
            r_rsp_valid_b <= r_p_valid && r_p_id;

            // Read data was driven by the SRAM on the preceding negedge.
            if (r_p_valid && r_p_rd) begin
                if (r_p_id) r_rsp_rdata_b <= sram_rd;
                else        r_rsp_rdata_a <= sram_rd;
            end

            case (r_state)
                c_st_init: begin
                    if (INIT_EN != 0) begin
                        r_ce_n <= 1'b0;
                        r_we_n <= 1'b0;
                        r_addr <= r_cnt;
                        r_wd   <= INIT_VALUE;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == c_last_addr) begin
                            r_state     <= c_st_run;
                            r_init_done <= 1'b1;
                        end
                    end else begin
                        r_state     <= c_st_run;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_gnt_a) begin
                        r_ce_n    <= 1'b0;
                        r_we_n    <= ~req_we_a;
                        r_addr    <= req_addr_a;
                        if (req_we_a) r_wd <= req_wdata_a;
                        r_p_valid <= 1'b1;
                        r_p_id    <= 1'b0;
                        r_p_rd    <= ~req_we_a;
                        r_last_b  <= 1'b0;
                    end else if (w_gnt_b) begin
                        r_ce_n    <= 1'b0;
                        r_we_n    <= ~req_we_b;
                        r_addr    <= req_addr_b;
                        if (req_we_b) r_wd <= req_wdata_b;
                        r_p_valid <= 1'b1;
                        r_p_id    <= 1'b1;
                        r_p_rd    <= ~req_we_b;
                        r_last_b  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready_a = w_gnt_a;
    assign req_ready_b = w_gnt_b;
    assign rsp_valid_a = r_rsp_valid_a;
    assign rsp_valid_b = r_rsp_valid_b;
    assign rsp_rdata_a = r_rsp_rdata_a;
    assign rsp_rdata_b = r_rsp_rdata_b;
    assign init_done   = r_init_done;
    assign sram_ce_n   = r_ce_n;
    assign sram_we_n   = r_we_n;
    assign sram_addr   = r_addr;
    assign sram_wd     = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_rr_access_ctrl
// Randomized bench for sram_rr_access_ctrl against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_sram_rr_access_ctrl;

    localparam int          c_aw   = 6;
    localparam int          c_dw   = 32;
    localparam logic [31:0] c_init = 32'hA5A5_A5A5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            va = 1'b0, wa = 1'b0, vb = 1'b0, wb = 1'b0;
    logic [c_aw-1:0] aa = '0, ab = '0;
    logic [c_dw-1:0] da = '0, db = '0;
    logic            ready_a, ready_b, rv_a, rv_b, init_done;
    logic [c_dw-1:0] rd_a, rd_b;
    logic            ce_n, we_n;
    logic [c_aw-1:0] s_addr;
    logic [c_dw-1:0] s_wd;
    logic [c_dw-1:0] s_rd = '0;

    logic            ready_a2, ready_b2, rv_a2, rv_b2, init_done2, ce_n2, we_n2;
    logic [c_dw-1:0] rd_a2, rd_b2, s_wd2;
    logic [c_aw-1:0] s_addr2;

    always #5 clk = ~clk;

    sram_rr_access_ctrl #(.AW(c_aw), .DW(c_dw), .DEPTH(64), .INIT_EN(1), .INIT_VALUE(c_init)) dut (
        .clk(clk), .rst(rst),
        .req_valid_a(va), .req_ready_a(ready_a), .req_we_a(wa), .req_addr_a(aa), .req_wdata_a(da),
        .rsp_valid_a(rv_a), .rsp_rdata_a(rd_a),
        .req_valid_b(vb), .req_ready_b(ready_b), .req_we_b(wb), .req_addr_b(ab), .req_wdata_b(db),
        .rsp_valid_b(rv_b), .rsp_rdata_b(rd_b),
        .init_done(init_done), .sram_ce_n(ce_n), .sram_we_n(we_n),
        .sram_addr(s_addr), .sram_wd(s_wd), .sram_rd(s_rd)
    );

    sram_rr_access_ctrl #(.AW(c_aw), .DW(c_dw), .DEPTH(64), .INIT_EN(0), .INIT_VALUE(c_init)) dut_noinit (
        .clk(clk), .rst(rst),
        .req_valid_a(1'b0), .req_ready_a(ready_a2), .req_we_a(1'b0), .req_addr_a(6'd0), .req_wdata_a(32'd0),
        .rsp_valid_a(rv_a2), .rsp_rdata_a(rd_a2),
        .req_valid_b(1'b0), .req_ready_b(ready_b2), .req_we_b(1'b0), .req_addr_b(6'd0), .req_wdata_b(32'd0),
        .rsp_valid_b(rv_b2), .rsp_rdata_b(rd_b2),
        .init_done(init_done2), .sram_ce_n(ce_n2), .sram_we_n(we_n2),
        .sram_addr(s_addr2), .sram_wd(s_wd2), .sram_rd(32'd0)
    );

    // Behavioural SRAM: write commits on posedge, read data appears on negedge.
    logic [c_dw-1:0] mem [64];
    always @(posedge clk) if (!ce_n && !we_n) mem[s_addr] <= s_wd;
    always @(negedge clk) if (!ce_n && we_n) s_rd <= mem[s_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    // Transaction-level reference state
    logic [c_dw-1:0] ref_mem [64];
    logic            last_b = 1'b0;
    logic            pend_v = 1'b0, pend_id = 1'b0, pend_rd = 1'b0;
    logic [c_dw-1:0] pend_data = '0;
    logic [c_dw-1:0] exp_rd_a = '0, exp_rd_b = '0;

    task automatic cycle(input logic iva, input logic iwa, input logic [c_aw-1:0] iaa, input logic [c_dw-1:0] ida,
                         input logic ivb, input logic iwb, input logic [c_aw-1:0] iab, input logic [c_dw-1:0] idb);
        logic ga, gb, cw;
        logic [c_aw-1:0] ca;
        logic [c_dw-1:0] cd;
        va = iva; wa = iwa; aa = iaa; da = ida;
        vb = ivb; wb = iwb; ab = iab; db = idb;
        ga = iva && (!ivb || last_b);
        gb = ivb && !ga;
        #1;
        check("ready_a", ready_a, ga);
        check("ready_b", ready_b, gb);
        @(posedge clk); #1;
        if (pend_v && pend_rd) begin
            if (pend_id) exp_rd_b = pend_data;
            else         exp_rd_a = pend_data;
        end
        check("rsp_valid_a", rv_a, pend_v && !pend_id);
        check("rsp_valid_b", rv_b, pend_v && pend_id);
        check("rsp_rdata_a", rd_a, exp_rd_a);
        check("rsp_rdata_b", rd_b, exp_rd_b);
        if (ga || gb) begin
            cw = gb ? iwb : iwa;
            ca = gb ? iab : iaa;
            cd = gb ? idb : ida;
            check("ce_n_acc", ce_n, 1'b0);
            check("we_n_acc", we_n, !cw);
            check("addr_acc", s_addr, ca);
            if (cw) check("wd_acc", s_wd, cd);
            pend_data = ref_mem[ca];
            if (cw) ref_mem[ca] = cd;
            pend_v = 1'b1; pend_id = gb; pend_rd = !cw; last_b = gb;
        end else begin
            check("ce_n_idle", ce_n, 1'b1);
            check("we_n_idle", we_n, 1'b1);
            pend_v = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ce_n", ce_n, 1'b1);
        check("rst_we_n", we_n, 1'b1);
        check("rst_addr", s_addr, '0);
        check("rst_wd", s_wd, '0);
        check("rst_rv_a", rv_a, 1'b0);
        check("rst_rv_b", rv_b, 1'b0);
        check("rst_rd_a", rd_a, '0);
        check("rst_rd_b", rd_b, '0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_init_done_noinit", init_done2, 1'b0);

        // Init sweep with A holding a request that must not be accepted
        rst = 1'b0;
        va = 1'b1; wa = 1'b0; aa = 6'd9;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("init_ready_a", ready_a, 1'b0);
            @(posedge clk); #1;
            check("init_ce_n", ce_n, 1'b0);
            check("init_we_n", we_n, 1'b0);
            check("init_addr", s_addr, i[5:0]);
            check("init_wd", s_wd, c_init);
            check("init_done", init_done, i == 63);
            if (i == 0) check("noinit_done", init_done2, 1'b1);
            check("noinit_ce_n", ce_n2, 1'b1);
            check("noinit_we_n", we_n2, 1'b1);
        end
        va = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = c_init;

        cycle(1, 0, 6'd17, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("init_value_read", rd_a, c_init);

        cycle(1, 1, 6'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cycle(1, 0, 6'd5, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("raw_read", rd_a, 32'hDEAD_BEEF);

        for (int i = 0; i < 6; i++)
            cycle(1, 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
                  1, 1'($urandom), 6'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 0, 1, 1'($urandom), 6'($urandom_range(0, 7)), $urandom);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), $urandom);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after a read is accepted squashes its response
        va = 1'b1; wa = 1'b0; aa = 6'd3; vb = 1'b0;
        #1;
        check("pre_rst_ready_a", ready_a, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_ce_n", ce_n, 1'b0);
        rst = 1'b1; va = 1'b0;
        @(posedge clk); #1;
        check("squash_rv_a", rv_a, 1'b0);
        check("squash_ce_n", ce_n, 1'b1);
        check("squash_init_done", init_done, 1'b0);
        check("squash_noinit_done", init_done2, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart_rv_a", rv_a, 1'b0);
        check("restart_ce_n", ce_n, 1'b0);
        check("restart_we_n", we_n, 1'b0);
        check("restart_addr", s_addr, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
